// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX decoder (master) and muldiv_seq (slave).
interface muldiv_seq_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        read_hilo;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, read_hilo, flush,
    input  busy, stall, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, read_hilo, flush,
    output busy, stall, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer and HI/LO owner: 32 RUN cycles, FIX for sign correction, ACC for the
// accumulate family, which exists only when MULDIV_ACC_EN is defined (otherwise Op 4-7 are ignored).
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);
  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

`ifdef MULDIV_ACC_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_ACC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
`endif

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] p_q;
  logic [31:0] opb_q, a_raw_q, hi_q, lo_q;
  logic        is_div_q, neg_res_q, neg_rem_q, dz_q, done_q, dz_pulse_q;
`ifdef MULDIV_ACC_EN
  logic        is_acc_q, is_sub_q;
  logic        op_acc, op_sub;
`endif

  logic        op_mul, op_div, op_sgn, accept, run_op, busy;
  logic        a_neg, b_neg, div_take;
  logic [31:0] a_mag, b_mag, rem_sub, quot_fix, rem_fix;
  logic [32:0] mul_sum, rem_sh;
  logic [63:0] mul_next, div_next, prod_fix;

  always_comb begin
    op_mul = 1'b0;
    op_div = 1'b0;
    op_sgn = 1'b0;
`ifdef MULDIV_ACC_EN
    op_acc = 1'b0;
    op_sub = 1'b0;
`endif
    case (bus.op)
      OP_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
      OP_MULTU: op_mul = 1'b1;
      OP_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
      OP_DIVU:  op_div = 1'b1;
`ifdef MULDIV_ACC_EN
      OP_MADD:  begin op_mul = 1'b1; op_acc = 1'b1; op_sgn = 1'b1; end
      OP_MADDU: begin op_mul = 1'b1; op_acc = 1'b1; end
      OP_MSUB:  begin op_mul = 1'b1; op_acc = 1'b1; op_sgn = 1'b1; op_sub = 1'b1; end
      OP_MSUBU: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign accept = (state_q == S_IDLE) & bus.start & ~bus.flush;
  assign run_op = accept & (op_mul | op_div);

  assign a_neg = op_sgn & bus.a[31];
  assign b_neg = op_sgn & bus.b[31];
  assign a_mag = a_neg ? (~bus.a + 32'd1) : bus.a;
  assign b_mag = b_neg ? (~bus.b + 32'd1) : bus.b;

  // Multiply: P = {partial, multiplier}; add multiplicand into the top when the low bit is set, then shift right.
  assign mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next = {mul_sum, p_q[31:1]};

  // Divide: P = {remainder, dividend/quotient}; the quotient bit shifts in at the bottom.
  assign rem_sh   = {p_q[63:32], p_q[31]};
  assign div_take = (rem_sh >= {1'b0, opb_q});
  assign rem_sub  = rem_sh[31:0] - opb_q;
  assign div_next = div_take ? {rem_sub, p_q[30:0], 1'b1} : {rem_sh[31:0], p_q[30:0], 1'b0};

  assign prod_fix = neg_res_q ? (~p_q + 64'd1) : p_q;
  assign quot_fix = neg_res_q ? (~p_q[31:0] + 32'd1) : p_q[31:0];
  assign rem_fix  = neg_rem_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (run_op) state_d = S_RUN;
        S_RUN:  if (cnt_q == 5'd31) state_d = S_FIX;
`ifdef MULDIV_ACC_EN
        S_FIX:  state_d = is_acc_q ? S_ACC : S_IDLE;
`else
        S_FIX:  state_d = S_IDLE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    bus.busy     = busy;
    bus.stall    = busy & (bus.start | bus.read_hilo);
    bus.done     = done_q;
    bus.div_zero = dz_pulse_q;
    bus.hi       = hi_q;
    bus.lo       = lo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 5'd0;
      p_q        <= 64'd0;
      opb_q      <= 32'd0;
      a_raw_q    <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
`ifdef MULDIV_ACC_EN
      is_acc_q   <= 1'b0;
      is_sub_q   <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
      cnt_q      <= (state_q == S_RUN && !bus.flush) ? cnt_q + 5'd1 : 5'd0;
      if (accept && bus.op == OP_MTHI) hi_q <= bus.a;
      if (accept && bus.op == OP_MTLO) lo_q <= bus.a;
      if (run_op) begin
        is_div_q  <= op_div;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        dz_q      <= op_div & (bus.b == 32'd0);
        a_raw_q   <= bus.a;
        p_q       <= {32'd0, op_div ? a_mag : b_mag};
        opb_q     <= op_div ? b_mag : a_mag;
`ifdef MULDIV_ACC_EN
        is_acc_q  <= op_acc;
        is_sub_q  <= op_sub;
`endif
      end
      if (!bus.flush) begin
        case (state_q)
          S_RUN: p_q <= is_div_q ? div_next : mul_next;
          S_FIX: begin
            if (is_div_q) begin
              if (dz_q) {hi_q, lo_q} <= {a_raw_q, 32'hFFFF_FFFF};
              else      {hi_q, lo_q} <= {rem_fix, quot_fix};
              done_q     <= 1'b1;
              dz_pulse_q <= dz_q;
            end
`ifdef MULDIV_ACC_EN
            else if (is_acc_q) begin
              p_q <= prod_fix;
            end
`endif
            else begin
              {hi_q, lo_q} <= prod_fix;
              done_q       <= 1'b1;
            end
          end
`ifdef MULDIV_ACC_EN
          S_ACC: begin
            {hi_q, lo_q} <= is_sub_q ? ({hi_q, lo_q} - p_q) : ({hi_q, lo_q} + p_q);
            done_q       <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic reference model with per-cycle compare, directed literal vectors, random traffic.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst;
  muldiv_seq_if bus();
  muldiv_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result computed with plain arithmetic at accept, released after a fixed latency.
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          p_dz = 0, m_done = 0, m_dz = 0;

  task automatic model_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [63:0] prod, hl;
    sa = a;
    sb = b;
    p_dz = 0;
    prod = 64'd0;
    case (op)
      4'd0: begin prod = longint'(sa) * longint'(sb); {p_hi, p_lo} = prod; m_left = 33; end
      4'd1: begin prod = {32'd0, a} * {32'd0, b}; {p_hi, p_lo} = prod; m_left = 33; end
      4'd2: begin
        if (b == 0) begin p_hi = a; p_lo = 32'hFFFFFFFF; p_dz = 1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin p_lo = 32'h80000000; p_hi = 0; end
        else begin p_lo = sa / sb; p_hi = sa % sb; end
        m_left = 33;
      end
      4'd3: begin
        if (b == 0) begin p_hi = a; p_lo = 32'hFFFFFFFF; p_dz = 1; end
        else begin p_lo = a / b; p_hi = a % b; end
        m_left = 33;
      end
`ifdef MULDIV_ACC_EN
      4'd4, 4'd5, 4'd6, 4'd7: begin
        if (op == 4'd4 || op == 4'd6) prod = longint'(sa) * longint'(sb);
        else prod = {32'd0, a} * {32'd0, b};
        hl = {m_hi, m_lo};
        hl = (op >= 4'd6) ? hl - prod : hl + prod;
        {p_hi, p_lo} = hl;
        m_left = 34;
      end
`endif
      4'd8: m_hi = a;
      4'd9: m_lo = a;
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_done = 0; m_dz = 0;
    end else begin
      m_done = 0;
      m_dz = 0;
      if (m_left > 0) begin
        if (bus.flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dz = p_dz; end
        end
      end else if (bus.start && !bus.flush) begin
        model_accept(bus.op, bus.a, bus.b);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("busy", bus.busy, m_left > 0);
      chk("done", bus.done, m_done);
      chk("div_zero", bus.div_zero, m_dz);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("stall", bus.stall, (m_left > 0) && (bus.start || bus.read_hilo));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    bus.start = 1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #2;
    bus.start = 0;
  endtask

  task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ebusy, input bit edz);
    int nb;
    bit seen;
    issue(op, a, b);
    nb = 0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      if (bus.done) begin
        seen = 1;
        chk({nm, " dz"}, bus.div_zero, edz);
        chk({nm, " hi"}, bus.hi, ehi);
        chk({nm, " lo"}, bus.lo, elo);
      end
    end
    chk({nm, " busy_cycles"}, nb, ebusy);
    chk({nm, " done_seen"}, seen, 1);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic [31:0] ehi, input logic [31:0] elo);
    issue(op, a, 32'd0);
    @(negedge clk);
    chk("mt busy", bus.busy, 0);
    chk("mt hi", bus.hi, ehi);
    chk("mt lo", bus.lo, elo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'd1;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb, nd;
    bit seen;
    rst = 1;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.read_hilo = 0; bus.flush = 0;
    #1;
    chk("reset busy", bus.busy, 0);
    chk("reset hi", bus.hi, 0);
    chk("reset lo", bus.lo, 0);
    #21 rst = 0;

    do_op("MULT", 4'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 33, 0);
    do_op("MULTU", 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 0);
    do_op("DIV", 4'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0);
    do_op("DIVU0", 4'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 33, 1);
    do_op("DIVOVF", 4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 0);

    mt(4'd8, 32'h0, 32'h0, 32'h80000000);
    mt(4'd9, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
`ifdef MULDIV_ACC_EN
    do_op("MADD", 4'd4, 32'd1, 32'd1, 32'd1, 32'd0, 34, 0);
`else
    issue(4'd4, 32'd1, 32'd1);
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy) nb++;
    end
    chk("MADD off busy_cycles", nb, 0);
    chk("MADD off hi", bus.hi, 32'h0);
    chk("MADD off lo", bus.lo, 32'hFFFFFFFF);
`endif

    // Hazards: MFHI then a second request while busy.
    issue(4'd0, 32'd5, 32'd6);
    bus.read_hilo = 1;
    @(negedge clk);
    chk("stall readhilo", bus.stall, 1);
    @(posedge clk); #2;
    bus.read_hilo = 0;
    bus.start = 1; bus.op = 4'd3; bus.a = 32'd99; bus.b = 32'd4;
    @(negedge clk);
    chk("stall start", bus.stall, 1);
    @(posedge clk); #2;
    bus.start = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("hazard done_seen", seen, 1);
    chk("hazard hi", bus.hi, 32'd0);
    chk("hazard lo", bus.lo, 32'd30);
    @(negedge clk);
    chk("hazard second not taken", bus.busy, 0);

    // Flush in the 10th RUN cycle of a DIV.
    issue(4'd2, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2 bus.flush = 1;
    @(posedge clk); #2;
    bus.flush = 0;
    @(negedge clk);
    chk("flush busy", bus.busy, 0);
    chk("flush hi", bus.hi, 32'd0);
    chk("flush lo", bus.lo, 32'd30);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("flush no done", nd, 0);

    // Flush and Start together in IDLE: request dropped.
    @(posedge clk); #2;
    bus.start = 1; bus.flush = 1; bus.op = 4'd0; bus.a = 32'd3; bus.b = 32'd3;
    @(posedge clk); #2;
    bus.start = 0; bus.flush = 0;
    @(negedge clk);
    chk("flush+start busy", bus.busy, 0);

    // Reset in the middle of a MULT.
    issue(4'd0, 32'd7, 32'd9);
    bus.read_hilo = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre-reset stall", bus.stall, 1);
    #3 rst = 1;
    #1;
    chk("midreset busy", bus.busy, 0);
    chk("midreset stall", bus.stall, 0);
    chk("midreset done", bus.done, 0);
    chk("midreset dz", bus.div_zero, 0);
    chk("midreset hi", bus.hi, 0);
    chk("midreset lo", bus.lo, 0);
    @(posedge clk); #2;
    rst = 0;
    bus.read_hilo = 0;

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      bus.start     = ($urandom % 4) == 0;
      bus.op        = 4'($urandom_range(0, 15));
      bus.a         = pick();
      bus.b         = pick();
      bus.read_hilo = $urandom % 2;
      bus.flush     = ($urandom % 150) == 0;
    end
    @(posedge clk); #2;
    bus.start = 0; bus.read_hilo = 0; bus.flush = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
